// File: rtl/sysid_checker.sv
// sysid_checker: reads sysid words 0 (ID) and 1 (timestamp) over Avalon-MM and flags mismatches.
// Optional macro SYSID_CHECKER_TIMEOUT_EN aborts a run after TIMEOUT_CYCLES consecutive stalls.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0001_2345,
  parameter logic [31:0] EXPECTED_TS    = 32'h53A6_BD01,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        timeout
);
  typedef enum logic [2:0] {LAUNCH, RD_ID, LAT_ID, RD_TS, LAT_TS, COMPARE, DONE} state_t;
  state_t r_state;
  logic r_read, r_addr, r_busy, r_done, r_id_ok, r_ts_ok, r_to;
  logic [31:0] r_id, r_ts;
  logic [1:0] r_lat;
  logic w_rd, w_lat, w_second, w_accept, w_cap, w_to;
  if (READ_LATENCY < 0 || READ_LATENCY > 3 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("sysid_checker: parameter out of range");
  end
  assign w_rd = (r_state == RD_ID) || (r_state == RD_TS);
  assign w_lat = (r_state == LAT_ID) || (r_state == LAT_TS);
  assign w_second = (r_state == RD_TS) || (r_state == LAT_TS);
  assign w_accept = w_rd && !avm_waitrequest;
  // zero latency captures in the accept cycle, otherwise when the counter reaches the latency
  assign w_cap = !w_to && ((READ_LATENCY == 0) ? w_accept : (w_lat && r_lat == 2'(READ_LATENCY)));
`ifdef SYSID_CHECKER_TIMEOUT_EN
  logic [15:0] r_stall;
  assign w_to = w_rd && (r_stall == 16'(TIMEOUT_CYCLES));
  always_ff @(posedge clock)
    r_stall <= (reset || r_state == LAUNCH || w_accept) ? '0 : r_stall + 16'(w_rd && avm_waitrequest);
`else
  assign w_to = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= LAUNCH;
      r_read  <= 1'b0;
      r_addr  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_id_ok <= 1'b0;
      r_ts_ok <= 1'b0;
      r_to    <= 1'b0;
      r_id    <= '0;
      r_ts    <= '0;
      r_lat   <= '0;
    end else if (w_cap) begin
      if (w_second) begin
        r_ts    <= avm_readdata;
        r_read  <= 1'b0;
        r_state <= COMPARE;
      end else begin
        r_id    <= avm_readdata;
        r_read  <= 1'b1;
        r_addr  <= 1'b1;
        r_state <= RD_TS;
      end
    end else begin
      case (r_state)
        LAUNCH: begin
          r_done  <= 1'b0;
          r_id_ok <= 1'b0;
          r_ts_ok <= 1'b0;
          r_to    <= 1'b0;
          r_busy  <= 1'b1;
          r_read  <= 1'b1;
          r_addr  <= 1'b0;
          r_state <= RD_ID;
        end
        RD_ID, RD_TS:
          if (w_to) begin
            r_read  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_to    <= 1'b1;
            r_id_ok <= 1'b0;
            r_ts_ok <= 1'b0;
            r_state <= DONE;
          end else if (w_accept) begin
            r_read  <= 1'b0;
            r_lat   <= 2'd1;
            r_state <= w_second ? LAT_TS : LAT_ID;
          end
        LAT_ID, LAT_TS: r_lat <= r_lat + 2'd1;
        COMPARE: begin
          r_id_ok <= r_id == EXPECTED_ID;
          r_ts_ok <= r_ts == EXPECTED_TS;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE:
          if (start) begin
            r_done  <= 1'b0;
            r_id_ok <= 1'b0;
            r_ts_ok <= 1'b0;
            r_to    <= 1'b0;
            r_state <= LAUNCH;
          end
        default: r_state <= LAUNCH;
      endcase
    end
  end
  assign avm_read = r_read;
  assign avm_address = r_addr;
  assign busy = r_busy;
  assign done = r_done;
  assign id_ok = r_id_ok;
  assign ts_ok = r_ts_ok;
  assign id_value = r_id;
  assign ts_value = r_ts;
  assign timeout = r_to;
endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: two checkers (latency 0 and 2) against a transaction-level model with a random slave.
module tb_sysid_checker;
  localparam logic [31:0] EXP_ID = 32'h0001_2345;
  localparam logic [31:0] EXP_TS = 32'h53A6_BD01;
`ifdef SYSID_CHECKER_TIMEOUT_EN
  localparam int TO = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO = 255;
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic wreq [2];
  logic [31:0] rdata [2];
  logic d_addr [2], d_read [2], d_busy [2], d_done [2], d_idok [2], d_tsok [2], d_to [2];
  logic [31:0] d_id [2], d_ts [2];
  int vectors = 0, miscompares = 0;
  int wait_mode = 0, bad_mode = 0;
  logic m_read [2], m_addr [2], m_busy [2], m_done [2], m_idok [2], m_tsok [2], m_to [2];
  logic m_valid [2], m_launch [2], m_fin [2], s_paddr [2];
  logic [31:0] m_id [2], m_ts [2];
  int m_word [2], m_lat [2], m_stall [2], s_pend [2], s_run [2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g
    sysid_checker #(.READ_LATENCY(2 * k), .TIMEOUT_CYCLES(TO)) u (
      .clock(clk), .reset(rst), .start(start),
      .avm_address(d_addr[k]), .avm_read(d_read[k]), .avm_readdata(rdata[k]),
      .avm_waitrequest(wreq[k]), .busy(d_busy[k]), .done(d_done[k]),
      .id_ok(d_idok[k]), .ts_ok(d_tsok[k]), .id_value(d_id[k]), .ts_value(d_ts[k]),
      .timeout(d_to[k]));
  end

  function automatic logic [31:0] word_for(input logic a);
    logic [31:0] good;
    good = a ? EXP_TS : EXP_ID;
    if (bad_mode == 1) return a ? good : good + 32'd1;
    if (bad_mode == 2 && $urandom_range(0, 1) == 1) return good ^ (32'd1 << $urandom_range(0, 31));
    return good;
  endfunction

  task automatic chk1(input string name, input int i, input logic act, input logic exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s u%0d: got %b, want %b at %0t", name, i, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s u%0d: got %h, want %h at %0t", name, i, act, exp, $time);
    end
  endtask

  task automatic capture(input int i, input logic [31:0] v);
    if (m_word[i] == 0) begin
      m_id[i] = v; m_word[i] = 1; m_read[i] = 1'b1; m_addr[i] = 1'b1;
    end else begin
      m_ts[i] = v; m_word[i] = 2; m_read[i] = 1'b0;
    end
  endtask

  // Observe the current cycle, then choose inputs for the edge that ends it and advance the model.
  task automatic cyc(input logic rs, input logic st);
    @(negedge clk);
    for (int i = 0; i < 2; i++) if (m_valid[i]) begin
      vectors++;
      chk1("avm_read", i, d_read[i], m_read[i]);
      if (m_read[i]) chk1("avm_address", i, d_addr[i], m_addr[i]);
      chk1("busy", i, d_busy[i], m_busy[i]);
      chk1("done", i, d_done[i], m_done[i]);
      chk1("id_ok", i, d_idok[i], m_idok[i]);
      chk1("ts_ok", i, d_tsok[i], m_tsok[i]);
      chk1("timeout", i, d_to[i], m_to[i]);
      chk32("id_value", i, d_id[i], m_id[i]);
      chk32("ts_value", i, d_ts[i], m_ts[i]);
    end
    rst = rs;
    start = st;
    for (int i = 0; i < 2; i++) begin
      int rl;
      logic w, acc;
      logic [31:0] rd;
      rl = 2 * i;
      w = (wait_mode == 3) || (wait_mode == 1 && s_run[i] < 3) || (wait_mode == 2 && $urandom_range(0, 2) == 0);
      acc = d_read[i] && !w;
      if (rl == 0) rd = acc ? word_for(d_addr[i]) : $urandom();
      else rd = (s_pend[i] == 1) ? word_for(s_paddr[i]) : $urandom();
      if (s_pend[i] > 0) s_pend[i]--;
      if (acc && rl > 0) begin s_pend[i] = rl; s_paddr[i] = d_addr[i]; end
      if (d_read[i]) s_run[i] = w ? s_run[i] + 1 : 0;
      wreq[i] = w;
      rdata[i] = rd;
      if (rs) begin
        m_valid[i] = 1'b1; m_read[i] = 1'b0; m_addr[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
        m_idok[i] = 1'b0; m_tsok[i] = 1'b0; m_to[i] = 1'b0; m_id[i] = '0; m_ts[i] = '0;
        m_launch[i] = 1'b1; m_fin[i] = 1'b0; m_word[i] = 0; m_lat[i] = 0; m_stall[i] = 0;
      end else if (!m_valid[i]) begin
      end else if (m_fin[i]) begin
        if (st) begin
          m_done[i] = 1'b0; m_idok[i] = 1'b0; m_tsok[i] = 1'b0; m_to[i] = 1'b0;
          m_fin[i] = 1'b0; m_launch[i] = 1'b1;
        end
      end else if (m_launch[i]) begin
        m_launch[i] = 1'b0; m_busy[i] = 1'b1; m_read[i] = 1'b1; m_addr[i] = 1'b0;
        m_word[i] = 0; m_stall[i] = 0;
      end else if (m_lat[i] > 0) begin
        if (m_lat[i] == 1) capture(i, rd);
        m_lat[i]--;
      end else if (m_read[i]) begin
        if (TO_EN && m_stall[i] == TO) begin
          m_read[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b1; m_to[i] = 1'b1;
          m_idok[i] = 1'b0; m_tsok[i] = 1'b0; m_fin[i] = 1'b1;
        end else if (!w) begin
          m_stall[i] = 0;
          if (rl == 0) capture(i, rd);
          else begin m_read[i] = 1'b0; m_lat[i] = rl; end
        end else m_stall[i]++;
      end else begin
        m_idok[i] = (m_id[i] == EXP_ID);
        m_tsok[i] = (m_ts[i] == EXP_TS);
        m_done[i] = 1'b1; m_busy[i] = 1'b0; m_fin[i] = 1'b1;
      end
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0; s_pend[i] = 0; s_run[i] = 0; wreq[i] = 1'b0; rdata[i] = '0;
    end
    repeat (3) cyc(1'b1, 1'b0);
    // zero-wait, good words: cycle-exact pins of the model
    cyc(1'b0, 1'b0);
    chk1("c1 read", 0, d_read[0], 1'b0);
    chk1("c1 busy", 0, d_busy[0], 1'b0);
    chk1("c1 done", 0, d_done[0], 1'b0);
    chk32("c1 id_value", 1, d_id[1], 32'h0);
    cyc(1'b0, 1'b0);
    chk1("c2 read", 0, d_read[0], 1'b1);
    chk1("c2 addr", 0, d_addr[0], 1'b0);
    chk1("c2 busy", 0, d_busy[0], 1'b1);
    cyc(1'b0, 1'b0);
    chk1("c3 read", 0, d_read[0], 1'b1);
    chk1("c3 addr", 0, d_addr[0], 1'b1);
    chk1("c3 read lat2", 1, d_read[1], 1'b0);
    cyc(1'b0, 1'b0);
    chk1("c4 read", 0, d_read[0], 1'b0);
    chk1("c4 done", 0, d_done[0], 1'b0);
    cyc(1'b0, 1'b1);
    chk1("c5 done", 0, d_done[0], 1'b1);
    chk1("c5 busy", 0, d_busy[0], 1'b0);
    chk1("c5 id_ok", 0, d_idok[0], 1'b1);
    chk1("c5 ts_ok", 0, d_tsok[0], 1'b1);
    chk32("c5 id_value", 0, d_id[0], 32'h0001_2345);
    chk32("c5 ts_value", 0, d_ts[0], 32'h53A6_BD01);
    // rerun with a wrong ID word; a start pulse mid-run must be ignored
    bad_mode = 1;
    cyc(1'b0, 1'b0);
    chk1("rerun done clr", 0, d_done[0], 1'b0);
    chk1("rerun id_ok clr", 0, d_idok[0], 1'b0);
    chk1("rerun ts_ok clr", 0, d_tsok[0], 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk1("busy mid-run", 0, d_busy[0], 1'b1);
    cyc(1'b0, 1'b0);
    chk1("lat2 done", 1, d_done[1], 1'b1);
    cyc(1'b0, 1'b0);
    chk1("bad done", 0, d_done[0], 1'b1);
    chk1("bad id_ok", 0, d_idok[0], 1'b0);
    chk1("bad ts_ok", 0, d_tsok[0], 1'b1);
    chk32("bad id_value", 0, d_id[0], 32'h0001_2346);
    cyc(1'b0, 1'b0);
    chk1("no queued start", 0, d_done[0], 1'b1);
    // three stall cycles per read on both instances
    bad_mode = 0;
    wait_mode = 1;
    cyc(1'b0, 1'b1);
    n = 0;
    do begin
      cyc(1'b0, 1'b0);
      n++;
    end while (!(d_done[0] && d_done[1]) && n < 60);
    if (n >= 60) begin
      miscompares++;
      $display("FAIL stall run: done not seen within %0d cycles, want both done", n);
    end
    chk1("stall id_ok", 1, d_idok[1], 1'b1);
    chk1("stall ts_ok", 1, d_tsok[1], 1'b1);
    // random stalls, data corruption, starts and resets
    wait_mode = 2;
    bad_mode = 2;
    repeat (3000) cyc($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0);
    // reset while the latency-2 instance waits for the timestamp
    wait_mode = 0;
    bad_mode = 0;
    cyc(1'b1, 1'b0);
    repeat (5) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk32("pre-reset id_value", 1, d_id[1], 32'h0001_2345);
    chk1("pre-reset read", 1, d_read[1], 1'b0);
    cyc(1'b0, 1'b0);
    chk1("post-reset busy", 1, d_busy[1], 1'b0);
    chk1("post-reset read", 1, d_read[1], 1'b0);
    chk32("post-reset id_value", 1, d_id[1], 32'h0);
    cyc(1'b0, 1'b0);
    chk1("restart read", 1, d_read[1], 1'b1);
    chk1("restart addr", 1, d_addr[1], 1'b0);
    // slave stuck in waitrequest
    wait_mode = 3;
    cyc(1'b0, 1'b1);
    repeat (300) cyc(1'b0, 1'b0);
`ifdef SYSID_CHECKER_TIMEOUT_EN
    chk1("stuck timeout", 0, d_to[0], 1'b1);
    chk1("stuck done", 0, d_done[0], 1'b1);
    chk1("stuck read", 0, d_read[0], 1'b0);
    chk1("stuck id_ok", 0, d_idok[0], 1'b0);
    chk1("stuck timeout", 1, d_to[1], 1'b1);
`else
    chk1("stuck busy", 0, d_busy[0], 1'b1);
    chk1("stuck timeout", 0, d_to[0], 1'b0);
    chk1("stuck read", 0, d_read[0], 1'b1);
    chk1("stuck busy", 1, d_busy[1], 1'b1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
